// File: rtl/frq_select_decoder.sv
// Measures the period of a divided clock in system-clock cycles and decodes it
// back to the 5-bit frequency-select code, with lock and loss-of-signal status.
module frq_select_decoder #(
    parameter int DIV_SCALE  = 4,
    parameter int TOL        = 1,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1024,
    parameter int LOCK_COUNT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    output logic [4:0]       freq_code,
    output logic             code_valid,
    output logic             code_err,
    output logic [4:0]       meas_code,
    output logic             locked,
    output logic             no_signal,
    output logic [CNT_W-1:0] period_out
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic {WAIT_EDGE, MEASURE} state_t;

    state_t             state;
    logic               s1, s2, s3;
    logic               rise;
    logic [CNT_W-1:0]   cnt;
    logic [RUN_W-1:0]   match_run;
    logic [RUN_W-1:0]   next_run;
    logic               hit;
    logic [4:0]         hit_code;
    logic [CNT_W:0]     target;
    logic [CNT_W:0]     diff;
    logic               timeout_hit;

    assign rise        = s2 & ~s3;
    assign timeout_hit = (({1'b0, cnt} + (CNT_W+1)'(1)) == (CNT_W+1)'(TIMEOUT));

    // At most one code window can contain cnt because the windows never overlap.
    always_comb begin
        hit      = 1'b0;
        hit_code = '0;
        target   = '0;
        diff     = '0;
        for (int unsigned k = 0; k < 32; k++) begin
            target = (CNT_W+1)'(2 * (int'(k) + 1) * DIV_SCALE);
            diff   = ({1'b0, cnt} >= target) ? ({1'b0, cnt} - target)
                                             : (target - {1'b0, cnt});
            if (diff <= (CNT_W+1)'(TOL)) begin
                hit      = 1'b1;
                hit_code = 5'(k);
            end
        end
    end

    always_comb begin
        next_run = RUN_W'(1);
        if (hit_code == meas_code && match_run != '0) begin
            if (match_run >= RUN_W'(LOCK_COUNT))
                next_run = RUN_W'(LOCK_COUNT);
            else
                next_run = match_run + RUN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_EDGE;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            cnt        <= '0;
            match_run  <= '0;
            freq_code  <= '0;
            code_valid <= 1'b0;
            code_err   <= 1'b0;
            meas_code  <= '0;
            locked     <= 1'b0;
            no_signal  <= 1'b0;
            period_out <= '0;
        end else begin
            s1         <= clk_in;
            s2         <= s1;
            s3         <= s2;
            code_valid <= 1'b0;
            code_err   <= 1'b0;
            if (state == WAIT_EDGE) begin
                cnt <= '0;
                if (rise) begin
                    cnt   <= CNT_W'(1);
                    state <= MEASURE;
                end
            end else if (rise) begin
                period_out <= cnt;
                cnt        <= CNT_W'(1);
                no_signal  <= 1'b0;
                if (hit) begin
                    code_valid <= 1'b1;
                    meas_code  <= hit_code;
                    match_run  <= next_run;
                    if (next_run == RUN_W'(LOCK_COUNT)) begin
                        locked    <= 1'b1;
                        freq_code <= hit_code;
                    end else begin
                        locked <= 1'b0;
                    end
                end else begin
                    code_err  <= 1'b1;
                    match_run <= '0;
                    locked    <= 1'b0;
                end
            end else if (timeout_hit) begin
                cnt       <= '0;
                no_signal <= 1'b1;
                locked    <= 1'b0;
                match_run <= '0;
                state     <= WAIT_EDGE;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_frq_select_decoder.sv
// Randomized and directed stimulus for frq_select_decoder, checked every cycle
// against a period/decode-history reference model.
module tb_frq_select_decoder;

    localparam int DIV_SCALE  = 4;
    localparam int TOL        = 1;
    localparam int CNT_W      = 16;
    localparam int TIMEOUT    = 1024;
    localparam int LOCK_COUNT = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             clk_in;
    logic [4:0]       freq_code;
    logic             code_valid;
    logic             code_err;
    logic [4:0]       meas_code;
    logic             locked;
    logic             no_signal;
    logic [CNT_W-1:0] period_out;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model state
    bit sh[3];
    bit m_meas;
    bit m_rise;
    int m_cnt;
    int hq[$];
    int e_fc, e_mc, e_po;
    bit e_cv, e_ce, e_lk, e_ns;

    frq_select_decoder #(
        .DIV_SCALE (DIV_SCALE),
        .TOL       (TOL),
        .CNT_W     (CNT_W),
        .TIMEOUT   (TIMEOUT),
        .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_in    (clk_in),
        .freq_code (freq_code),
        .code_valid(code_valid),
        .code_err  (code_err),
        .meas_code (meas_code),
        .locked    (locked),
        .no_signal (no_signal),
        .period_out(period_out)
    );

    always #5 clk = ~clk;

    // Nearest multiple of the code unit, then accept only if within TOL.
    function automatic int decode(int p);
        int unit = 2 * DIV_SCALE;
        int k    = (p + unit / 2) / unit - 1;
        int d;
        if (k < 0 || k > 31) return -1;
        d = p - (k + 1) * unit;
        if (d < 0) d = -d;
        return (d <= TOL) ? k : -1;
    endfunction

    function automatic bit history_locked(int k);
        if (k < 0 || hq.size() < LOCK_COUNT) return 1'b0;
        foreach (hq[i]) if (hq[i] != k) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        int k;
        if (reset) begin
            sh = '{0, 0, 0};
            m_meas = 0; m_cnt = 0; hq.delete();
            e_fc = 0; e_mc = 0; e_po = 0;
            e_cv = 0; e_ce = 0; e_lk = 0; e_ns = 0;
        end else begin
            m_rise = sh[1] && !sh[2];
            e_cv = 0; e_ce = 0;
            if (!m_meas) begin
                m_cnt = m_rise ? 1 : 0;
                m_meas = m_rise;
            end else if (m_rise) begin
                e_po  = m_cnt;
                k     = decode(m_cnt);
                m_cnt = 1;
                e_ns  = 0;
                hq.push_back(k);
                if (hq.size() > LOCK_COUNT) void'(hq.pop_front());
                if (k >= 0) begin
                    e_cv = 1; e_mc = k;
                end else begin
                    e_ce = 1;
                end
                e_lk = history_locked(k);
                if (e_lk) e_fc = k;
            end else if (m_cnt + 1 == TIMEOUT) begin
                e_ns = 1; e_lk = 0; hq.delete();
                m_meas = 0; m_cnt = 0;
            end else begin
                m_cnt++;
            end
            sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = clk_in;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            total++;
            if ({freq_code, code_valid, code_err, meas_code, locked, no_signal, period_out} !==
                {5'(e_fc), e_cv, e_ce, 5'(e_mc), e_lk, e_ns, CNT_W'(e_po)}) begin
                bad++;
                $display("FAIL cycle_compare t=%0t got fc=%0d v=%0b e=%0b mc=%0d lk=%0b ns=%0b po=%0d want fc=%0d v=%0b e=%0b mc=%0d lk=%0b ns=%0b po=%0d",
                         $time, freq_code, code_valid, code_err, meas_code, locked, no_signal, period_out,
                         e_fc, e_cv, e_ce, e_mc, e_lk, e_ns, e_po);
            end
        end
    end

    task automatic check(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_period(int p, int edges);
        for (int i = 0; i < edges; i++) begin
            clk_in = 1'b1; cyc(p / 2);
            clk_in = 1'b0; cyc(p - p / 2);
        end
    endtask

    initial begin
        reset = 1'b1; clk_in = 1'b0;
        cyc(3);
        chk_en = 1'b1;
        check("reset_locked", int'(locked), 0);
        check("reset_period", int'(period_out), 0);
        reset = 1'b0;
        cyc(2);

        check("dec_8",   decode(8),   0);
        check("dec_7",   decode(7),   0);
        check("dec_10",  decode(10),  -1);
        check("dec_33",  decode(33),  3);
        check("dec_256", decode(256), 31);
        check("dec_264", decode(264), -1);

        pulse_period(8, 4);
        check("p8_locked", int'(locked), 1);
        check("p8_code", int'(freq_code), 0);
        check("p8_period", int'(period_out), 8);

        pulse_period(24, 4);
        check("p24_code", int'(freq_code), 2);
        pulse_period(256, 4);
        check("p256_code", int'(freq_code), 31);
        check("p256_locked", int'(locked), 1);

        pulse_period(10, 3);
        check("p10_locked", int'(locked), 0);
        check("p10_code_held", int'(freq_code), 31);
        check("p10_period", int'(period_out), 10);
        pulse_period(7, 4);
        check("p7_meas", int'(meas_code), 0);
        pulse_period(9, 4);
        check("p9_locked", int'(locked), 1);

        pulse_period(48, 5);
        clk_in = 1'b0;
        cyc(TIMEOUT + 50);
        check("to_no_signal", int'(no_signal), 1);
        check("to_locked", int'(locked), 0);
        check("to_code_held", int'(freq_code), 5);
        pulse_period(48, 3);
        check("restart_no_signal", int'(no_signal), 0);

        pulse_period(16, 5);
        clk_in = 1'b1; cyc(4);
        reset = 1'b1; cyc(1);
        reset = 1'b0;
        check("midreset_locked", int'(locked), 0);
        check("midreset_code", int'(freq_code), 0);
        clk_in = 1'b0; cyc(4);
        pulse_period(16, 5);
        check("relock_code", int'(freq_code), 1);

        for (int i = 0; i < 6; i++) begin
            pulse_period(31, 1);
            pulse_period(33, 1);
        end
        check("jitter_locked", int'(locked), 1);
        check("jitter_code", int'(freq_code), 3);

        for (int i = 0; i < 40; i++) begin
            int k = int'($urandom_range(0, 15));
            int p = 2 * (k + 1) * DIV_SCALE + int'($urandom_range(0, 2)) - 1;
            if ($urandom_range(0, 7) == 0) p = p + 4;
            pulse_period(p, int'($urandom_range(1, 5)));
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1; cyc(1); reset = 1'b0;
            end
        end
        cyc(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
